muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV64M multiply/divide sequencer attached to the execute stage. It accepts one operation from execute, runs a one-bit-per-cycle shift-add multiply or restoring divide over a private datapath, and drives `exe_wait` to stall the pipeline until the result is ready. Execute muxes `result` onto `dataE_nxt.alu` in the cycle `done` is high.

## Interface
- No parameters; width fixed at 64 (XLEN from `common`).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: M-extension op present in execute; `op`, `a`, `b` stable while `exe_wait`=1.
- `op` in `mdu_op_t`: MUL, DIV, DIVU, REM, REMU (+ W forms when configured).
- `a` in 64: rs1 value.
- `b` in 64: rs2 value.
- `flush` in 1: synchronous abort; wins over everything except `reset`.
- `exe_wait` out 1: stall request to pipeline control.
- `done` out 1: one-cycle result strobe.
- `result` out 64: registered result; valid when `done`=1.

## Operation
- States: IDLE, COMPUTE, DONE.
- IDLE & `req_valid` & !`flush`: latch |a|, |b| (signed ops) or raw (unsigned/MUL), result signs, op; load counter to N-1 (N=64, 32 for W); -> COMPUTE.
- Special cases detected in IDLE skip COMPUTE, go directly to DONE:
  - divide by zero: DIV/DIVU quotient = all ones; REM/REMU = a.
  - signed overflow (a = 0x8000_0000_0000_0000, b = -1): DIV = a, REM = 0.
- COMPUTE: MUL adds shifted multiplicand when multiplier LSB set, shifts; divide does one restoring step per cycle (shift remainder, trial subtract, set quotient bit). Counter decrements; at 0 -> DONE.
- DONE: apply sign fix (quotient negated if signs differ; remainder takes dividend sign), select quotient/remainder/product low 64, register into `result`, `done`=1; -> IDLE.
- `exe_wait` = (IDLE & `req_valid`) | COMPUTE; low in DONE so pipeline advances on the result.
- `flush` in any state: -> IDLE next edge, `done` stays 0, `result` unchanged.
- `req_valid` in DONE is ignored (same instruction being retired); re-sampled in IDLE.
- Arithmetic: unsigned 64-bit internals, remainder register 65 bits for trial subtract; all wrap modulo 2^64.

## Timing
- Reset values: state IDLE, counter 0, `done` 0, `result` 0, `exe_wait` 0 (with `req_valid`=0).
- Request cycle = cycle 0 (accepted at its closing edge).
- Normal op: COMPUTE cycles 1..64, DONE cycle 65; `exe_wait` high cycles 0..64 (65 cycles).
- W op: COMPUTE 1..32, DONE 33.
- Special case: DONE in cycle 1; `exe_wait` high only cycle 0.
- Back-to-back: next request earliest in cycle after DONE.
- `reset` mid-operation: immediate return to reset values; no `done`.

## Configuration
- `MULDIV_WORD_EN` defined: MULW, DIVW, DIVUW, REMW, REMUW accepted; operate on a[31:0], b[31:0], 32 iterations, 32-bit result sign-extended to 64; special cases use 32-bit min/-1 and zero.
- Undefined: W encodings absent from `mdu_op_t`; only 64-bit ops; iteration count constant 64.

## Structure
- `mdu_op_t` enum and `mdu_state_t` go in `pipes`; the decode control bundle gains an `MduEn` bit and `mdu_op_t` field.
- One sub-module: `mdu_div_step`, combinational single restoring-divide step (remainder, divisor, dividend bit -> new remainder, quotient bit).

## Test plan
- MUL a=7, b=-3 -> `done` in cycle 65, `result`=0xFFFF_FFFF_FFFF_FFEB; `exe_wait` high exactly cycles 0..64.
- DIV a=-7, b=2 -> -3 (0xFFFF_FFFF_FFFF_FFFD); REM same -> -1; DIVU a=100, b=7 -> 14; REMU -> 2.
- DIVU a=5, b=0 -> all ones; REM a=5, b=0 -> 5; both `done` in cycle 1.
- DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000; REM -> 0; `done` in cycle 1.
- `flush` at cycle 10 of a DIV -> IDLE at cycle 11, no `done`; new MUL 3*4 issued cycle 11 -> `result`=12 at cycle 76.
- `reset` asserted mid-COMPUTE -> `exe_wait`, `done`, `result` 0 immediately; with `MULDIV_WORD_EN`, DIVW a=0xFFFF_FFFF_8000_0000, b=-1 -> 0xFFFF_FFFF_8000_0000.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative RV64M multiply/divide sequencer.
// MULDIV_WORD_EN adds the 32-bit W-form opcodes to mdu_op_t.
package muldiv_unit_pkg;

  localparam int XLEN = 64;
  localparam int CNTW = 6;

  // op[2]: divide family, op[1]: remainder, op[0]: unsigned, op[3]: word form
`ifdef MULDIV_WORD_EN
  typedef enum logic [3:0] {
    MUL   = 4'b0000,
    DIV   = 4'b0100,
    DIVU  = 4'b0101,
    REM   = 4'b0110,
    REMU  = 4'b0111,
    MULW  = 4'b1000,
    DIVW  = 4'b1100,
    DIVUW = 4'b1101,
    REMW  = 4'b1110,
    REMUW = 4'b1111
  } mdu_op_t;
`else
  typedef enum logic [2:0] {
    MUL  = 3'b000,
    DIV  = 3'b100,
    DIVU = 3'b101,
    REM  = 3'b110,
    REMU = 3'b111
  } mdu_op_t;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } mdu_state_t;

  typedef struct packed {
    logic    MduEn;
    mdu_op_t MduOp;
  } mdu_dec_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-divide step: shift the next dividend bit into the remainder,
// trial-subtract the divisor and keep the difference if it did not borrow.
module mdu_div_step
  import muldiv_unit_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_bit,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qbit
);

  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_diff;

  assign w_trial = {i_rem, i_bit};
  assign o_qbit  = (w_trial >= {1'b0, i_divisor});
  // When the subtract succeeds the true difference is below the divisor, so 64 bits hold it.
  assign w_diff  = w_trial[XLEN-1:0] - i_divisor;
  assign o_rem   = o_qbit ? w_diff : w_trial[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiply / restoring divide sequencer for RV64M.
// Define MULDIV_WORD_EN to accept the W forms (32 iterations, sign-extended result).
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  mdu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            exe_wait,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mdu_state_t      r_state, w_state_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [XLEN-1:0] r_acc, r_x, r_y;
  logic [XLEN-1:0] r_final, r_result;
  logic            r_is_mul, r_is_rem, r_word, r_q_neg, r_r_neg;

  logic            w_word, w_mul, w_signed, w_a_neg, w_b_neg;
  logic            w_b_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_a_eff, w_b_eff, w_a_abs, w_b_abs, w_spec_raw, w_spec;
  logic [XLEN-1:0] w_step_rem, w_acc_nxt, w_x_nxt, w_quo, w_rem, w_sel, w_final;
  logic            w_qbit;

`ifdef MULDIV_WORD_EN
  assign w_word = op[3];
`else
  assign w_word = 1'b0;
`endif

  assign w_mul    = ~op[2];
  assign w_signed = op[2] & ~op[0];
  assign w_a_eff  = w_word ? (w_signed ? sext32(a[31:0]) : {32'b0, a[31:0]}) : a;
  assign w_b_eff  = w_word ? (w_signed ? sext32(b[31:0]) : {32'b0, b[31:0]}) : b;
  assign w_a_neg  = w_signed & (w_word ? a[31] : a[XLEN-1]);
  assign w_b_neg  = w_signed & (w_word ? b[31] : b[XLEN-1]);
  assign w_a_abs  = w_a_neg ? -w_a_eff : w_a_eff;
  assign w_b_abs  = w_b_neg ? -w_b_eff : w_b_eff;

  assign w_b_zero  = w_word ? (b[31:0] == 32'd0) : (b == '0);
  assign w_ovf     = w_signed & (w_word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                                        : (a == {1'b1, {(XLEN-1){1'b0}}} && b == '1));
  assign w_special = op[2] & (w_b_zero | w_ovf);
  assign w_spec_raw = w_b_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
  assign w_spec     = w_word ? sext32(w_spec_raw[31:0]) : w_spec_raw;

  mdu_div_step u_div_step (
    .i_rem    (r_acc),
    .i_divisor(r_y),
    .i_bit    (r_x[XLEN-1]),
    .o_rem    (w_step_rem),
    .o_qbit   (w_qbit)
  );

  // r_x: multiplier (shifts right) or dividend/quotient (shifts left); r_y: multiplicand or divisor
  assign w_acc_nxt = r_is_mul ? (r_x[0] ? r_acc + r_y : r_acc) : w_step_rem;
  assign w_x_nxt   = r_is_mul ? {1'b0, r_x[XLEN-1:1]} : {r_x[XLEN-2:0], w_qbit};

  assign w_quo   = r_q_neg ? -w_x_nxt : w_x_nxt;
  assign w_rem   = r_r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_sel   = r_is_mul ? w_acc_nxt : (r_is_rem ? w_rem : w_quo);
  assign w_final = r_word ? sext32(w_sel[31:0]) : w_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    exe_wait    = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        exe_wait = req_valid;
        if (req_valid) w_state_nxt = w_special ? DONE : COMPUTE;
      end
      COMPUTE: begin
        exe_wait = 1'b1;
        if (r_cnt == '0) w_state_nxt = DONE;
      end
      DONE: begin
        done        = ~flush;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  // The final value is captured on entry to DONE so it is visible during the done cycle.
  assign result = done ? r_final : r_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_final  <= '0;
      r_result <= '0;
      r_is_mul <= 1'b0;
      r_is_rem <= 1'b0;
      r_word   <= 1'b0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
    end else if (!flush) begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_cnt    <= w_word ? CNTW'(31) : CNTW'(63);
            r_acc    <= '0;
            r_x      <= w_mul ? w_b_abs : (w_word ? {w_a_abs[31:0], 32'b0} : w_a_abs);
            r_y      <= w_mul ? w_a_abs : w_b_abs;
            r_is_mul <= w_mul;
            r_is_rem <= op[1];
            r_word   <= w_word;
            r_q_neg  <= w_a_neg ^ w_b_neg;
            r_r_neg  <= w_a_neg;
            if (w_special) r_final <= w_spec;
          end
        end
        COMPUTE: begin
          r_acc <= w_acc_nxt;
          r_x   <= w_x_nxt;
          if (r_is_mul) r_y <= {r_y[XLEN-2:0], 1'b0};
          if (r_cnt == '0) r_final <= w_final;
          else             r_cnt   <= r_cnt - CNTW'(1);
        end
        DONE: r_result <= r_final;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: expected results are queued at issue
// and popped when done strobes; latency and stall length are checked per op.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  mdu_op_t     op = MUL;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        flush = 1'b0;
  logic        exe_wait, done;
  logic [63:0] result;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [63:0] sb[$];

  muldiv_unit dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .exe_wait (exe_wait),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input mdu_op_t o, input logic [63:0] ia, input logic [63:0] ib);
    @(posedge clk); #1;
    req_valid = 1'b1;
    op = o;
    a = ia;
    b = ib;
  endtask

  // Cycle numbers are relative to the request cycle (cycle 0).
  task automatic wait_done(input string tag, input int start, input int exp_cyc);
    int          cyc;
    int          nw;
    logic        seen;
    logic [63:0] exp;
    cyc  = start;
    nw   = 0;
    seen = 1'b0;
    while (!seen && cyc < start + 200) begin
      @(negedge clk);
      if (exe_wait) nw++;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    if (seen) begin
      chk({tag, "_result"}, result, exp);
      chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
      chk({tag, "_wait_cycles"}, 64'(nw), 64'(exp_cyc - start));
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run(input string tag, input mdu_op_t o, input logic [63:0] ia,
                     input logic [63:0] ib, input logic [63:0] exp, input int lat);
    issue(o, ia, ib);
    sb.push_back(exp);
    wait_done(tag, 0, lat);
  endtask

  initial begin
    int nd;
    #3;
    chk("rst_exe_wait", 64'(exe_wait), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run("mul_7_m3",   MUL,  64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run("div_m7_2",   DIV,  -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("rem_m7_2",   REM,  -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run("div_7_m2",   DIV,  64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("rem_7_m2",   REM,  64'd7, -64'sd2, 64'd1, 65);
    run("divu_100_7", DIVU, 64'd100, 64'd7, 64'd14, 65);
    run("divu_5_0",   DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run("rem_5_0",    REM,  64'd5, 64'd0, 64'd5, 1);
    run("div_ovf",    DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, 1);
    run("rem_ovf",    REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run("mul_big",    MUL,  64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001, 65);

    // flush a divide in cycle 10, then issue MUL 3*4 in cycle 11
    issue(DIV, 64'd1000, 64'd3);
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) nd++;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    if (done) nd++;
    @(posedge clk); #1;
    flush = 1'b0;
    op = MUL;
    a = 64'd3;
    b = 64'd4;
    sb.push_back(64'd12);
    chk("flush_no_done", 64'(nd), 64'd0);
    wait_done("flush_then_mul", 11, 76);

    // asynchronous reset in the middle of COMPUTE
    issue(MUL, 64'd7, 64'd9);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
    end
    #3;
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("midrst_exe_wait", 64'(exe_wait), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst_no_done", 64'(nd), 64'd0);

    run("remu_100_7", REMU, 64'd100, 64'd7, 64'd2, 65);

`ifdef MULDIV_WORD_EN
    run("divw_ovf",   DIVW, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'hFFFF_FFFF_8000_0000, 1);
    run("mulw_7_m3",  MULW, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 33);
    run("divw_m7_2",  DIVW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run("remuw_5_0",  REMUW, 64'h1234_5678_0000_0005, 64'd0, 64'd5, 1);
`endif

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
